// File: rtl/stop_watch_lap.sv
// rtl/stop_watch_lap.sv - centisecond stopwatch with lap capture, pause/resume/clear and overflow flag
module stop_watch_lap #(
    parameter int CLK_PER_TICK = 10,
    parameter int MAX_MIN      = 59,
    parameter int WRAP         = 1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START_STOP,
    input  logic       LAP_RST,
    output logic [3:0] MIN_S10,
    output logic [3:0] MIN_S1,
    output logic [3:0] SEC_S10,
    output logic [3:0] SEC_S1,
    output logic [3:0] CS_S10,
    output logic [3:0] CS_S1,
    output logic       RUNNING,
    output logic       LAP_ACT,
    output logic       OVF
);

    localparam int             PW       = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [6:0]     MIN_LAST = 7'(MAX_MIN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [6:0]    cs, cs_nxt, min, min_nxt;
    logic [5:0]    sec, sec_nxt;
    logic [6:0]    lap_cs, lap_cs_nxt, lap_min, lap_min_nxt;
    logic [5:0]    lap_sec, lap_sec_nxt;
    logic          ovf, ovf_nxt;
    logic          lap_press, tick, at_max;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= S_IDLE;
            pre     <= '0;
            cs      <= '0;
            sec     <= '0;
            min     <= '0;
            lap_cs  <= '0;
            lap_sec <= '0;
            lap_min <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pre     <= pre_nxt;
            cs      <= cs_nxt;
            sec     <= sec_nxt;
            min     <= min_nxt;
            lap_cs  <= lap_cs_nxt;
            lap_sec <= lap_sec_nxt;
            lap_min <= lap_min_nxt;
            ovf     <= ovf_nxt;
        end
    end

    // START_STOP wins over LAP_RST when both arrive in the same cycle
    assign lap_press = LAP_RST && !START_STOP;
    assign at_max    = (cs == 7'd99) && (sec == 6'd59) && (min == MIN_LAST);

    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre;
        cs_nxt      = cs;
        sec_nxt     = sec;
        min_nxt     = min;
        lap_cs_nxt  = lap_cs;
        lap_sec_nxt = lap_sec;
        lap_min_nxt = lap_min;
        ovf_nxt     = ovf;
        tick        = 1'b0;
        case (state)
            S_IDLE: begin
                pre_nxt = '0;
                cs_nxt  = '0;
                sec_nxt = '0;
                min_nxt = '0;
                if (START_STOP) state_nxt = S_RUN;
            end
            S_RUN, S_LAP: begin
                tick    = (pre == PRE_LAST);
                pre_nxt = tick ? '0 : pre + 1'b1;
                if (state == S_RUN && lap_press) begin
                    lap_cs_nxt  = cs;
                    lap_sec_nxt = sec;
                    lap_min_nxt = min;
                end
                if (START_STOP)     state_nxt = S_STOP;
                else if (lap_press) state_nxt = (state == S_RUN) ? S_LAP : S_RUN;
                if (tick) begin
                    if (at_max) begin
                        ovf_nxt = 1'b1;
                        if (WRAP != 0) begin
                            cs_nxt  = '0;
                            sec_nxt = '0;
                            min_nxt = '0;
                        end else begin
                            state_nxt = S_STOP;
                        end
                    end else if (cs == 7'd99) begin
                        cs_nxt = '0;
                        if (sec == 6'd59) begin
                            sec_nxt = '0;
                            min_nxt = min + 7'd1;
                        end else begin
                            sec_nxt = sec + 6'd1;
                        end
                    end else begin
                        cs_nxt = cs + 7'd1;
                    end
                end
            end
            S_STOP: begin
                if (START_STOP) begin
                    state_nxt = S_RUN;
                end else if (LAP_RST) begin
                    state_nxt   = S_IDLE;
                    pre_nxt     = '0;
                    cs_nxt      = '0;
                    sec_nxt     = '0;
                    min_nxt     = '0;
                    lap_cs_nxt  = '0;
                    lap_sec_nxt = '0;
                    lap_min_nxt = '0;
                    ovf_nxt     = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        logic [3:0] t, u;
        t = 4'(v / 7'd10);
        u = 4'(v - 7'(t) * 7'd10);
        return {t, u};
    endfunction

    logic [6:0] disp_cs, disp_min;
    logic [5:0] disp_sec;

    assign disp_cs  = (state == S_LAP) ? lap_cs  : cs;
    assign disp_sec = (state == S_LAP) ? lap_sec : sec;
    assign disp_min = (state == S_LAP) ? lap_min : min;

    assign {MIN_S10, MIN_S1} = bcd2(disp_min);
    assign {SEC_S10, SEC_S1} = bcd2({1'b0, disp_sec});
    assign {CS_S10, CS_S1}   = bcd2(disp_cs);

    assign RUNNING = (state == S_RUN) || (state == S_LAP);
    assign LAP_ACT = (state == S_LAP);
    assign OVF     = ovf;

endmodule
